mem_responder: RTL and testbench

//  Memory-side responder for the control unit's rd/wr strobes: owns the

---
 rtl/mem_resp_pkg.sv | 11 +
 rtl/mem_responder_array.sv | 20 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and counter width for mem_responder.
package mem_resp_pkg;
    localparam int CNT_W = 3;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RWAIT = 3'd1,
        RDATA = 3'd2,
        WWAIT = 3'd3,
        WDONE = 3'd4
    } state_e;
endpackage

// File: rtl/mem_responder_array.sv
// mem_array: storage array, one synchronous write port and one combinational read port.
//   clk_i              clock
//   we_i/waddr_i/wdata_i  write port, committed on the rising edge
//   raddr_i/rdata_o       read port, registered by the caller
module mem_array #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);
    logic [DWIDTH-1:0] mem [2**AWIDTH];
    always_ff @(posedge clk_i)
        if (we_i) mem[waddr_i] <= wdata_i;
    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for rd/wr strobes with optional wait states.
//   clk, rst                       clock, synchronous active-high reset
//   rd, wr, addr, data_in          access strobes, address and write data from the CPU
//   data_out, data_oe, ready, err  registered read data, bus drive, done flag, error pulse
//   load, load_addr, load_data     preload port, honoured only when no strobe is active
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_oe,
    output logic              ready,
    output logic              err,
    input  logic              load,
    input  logic [AWIDTH-1:0] load_addr,
    input  logic [DWIDTH-1:0] load_data
);
    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d, raddr, fsm_waddr, waddr;
    logic [DWIDTH-1:0] data_q, data_d, dout_q, dout_d, fsm_wdata, wdata, rdata;
    logic              err_q, err_d, fsm_we, load_ok, we;
    mem_array #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_array (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dout_d    = dout_q;
        err_d     = 1'b0;
        fsm_we    = 1'b0;
        fsm_waddr = addr_q;
        fsm_wdata = data_q;
        raddr     = addr_q;
        case (state_q)
            IDLE: begin
                // Address comes straight from the bus so a zero-wait read lands on the accept edge.
                raddr = addr;
                err_d = (rd & wr) | (load & (rd | wr));
                if (rd & !wr) begin
                    addr_d = addr;
                    cnt_d  = WS;
                    if (WAIT_STATES == 0) begin
                        dout_d  = rdata;
                        state_d = RDATA;
                    end else state_d = RWAIT;
                end else if (wr & !rd) begin
                    addr_d = addr;
                    data_d = data_in;
                    cnt_d  = WS;
                    if (WAIT_STATES == 0) begin
                        fsm_we    = 1'b1;
                        fsm_waddr = addr;
                        fsm_wdata = data_in;
                        state_d   = WDONE;
                    end else state_d = WWAIT;
                end
            end
            RWAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!rd) state_d = IDLE;
                else if (cnt_q == CNT_W'(1)) begin
                    dout_d  = rdata;
                    state_d = RDATA;
                end
            end
            RDATA: state_d = rd ? RDATA : IDLE;
            WWAIT: begin
                // Posted write: completes regardless of wr; a read attempt here is a protocol error.
                err_d = rd;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_we  = 1'b1;
                    state_d = WDONE;
                end
            end
            WDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign load_ok  = load & !rd & !wr & !fsm_we;
    // Reset blocks every array write so an in-flight write is dropped.
    assign we       = !rst & (fsm_we | load_ok);
    assign waddr    = fsm_we ? fsm_waddr : load_addr;
    assign wdata    = fsm_we ? fsm_wdata : load_data;
    assign data_out = dout_q;
    assign data_oe  = state_q == RDATA;
    assign ready    = (state_q == RDATA) | (state_q == WDONE);
    assign err      = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at WAIT_STATES 0, 2 and 3 sharing one stimulus.
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       rst, rd, wr, load;
    logic [4:0] addr, load_addr;
    logic [7:0] data_in, load_data;
    logic [7:0] dout0, dout2, dout3;
    logic       oe0, oe2, oe3, rdy0, rdy2, rdy3, err0, err2, err3;
    int         n_checks = 0;
    int         n_errors = 0;
    always #5 clk = ~clk;
    mem_responder #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout0), .data_oe(oe0), .ready(rdy0), .err(err0),
        .load(load), .load_addr(load_addr), .load_data(load_data)
    );
    mem_responder #(.WAIT_STATES(2)) u2 (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout2), .data_oe(oe2), .ready(rdy2), .err(err2),
        .load(load), .load_addr(load_addr), .load_data(load_data)
    );
    mem_responder #(.WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout3), .data_oe(oe3), .ready(rdy3), .err(err3),
        .load(load), .load_addr(load_addr), .load_data(load_data)
    );
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; load = 1'b0;
        addr = '0; load_addr = '0; data_in = '0; load_data = '0;
        tick(2);
        rst = 1'b0;
        load = 1'b1; load_addr = 5'd3; load_data = 8'hA5;
        tick();
        load_addr = 5'd5; load_data = 8'h3C;
        tick();
        load = 1'b0;
        tick();
        // read then reset mid-access
        rd = 1'b1; addr = 5'd3;
        tick();
        check("pre_rst_dout", dout0, 8'hA5);
        rst = 1'b1;
        tick();
        check("rst_dout", dout0, 8'h00);
        check("rst_oe", {7'd0, oe0}, 8'd0);
        check("rst_ready", {7'd0, rdy0}, 8'd0);
        check("rst_err", {7'd0, err0}, 8'd0);
        rst = 1'b0; rd = 1'b0;
        tick();
        rd = 1'b1;
        tick();
        check("survive_dout", dout0, 8'hA5);
        rd = 1'b0;
        tick();
        // three-cycle read of addr 5, addr wiggled mid-read
        rd = 1'b1; addr = 5'd5;
        tick();
        check("r0_dout", dout0, 8'h3C);
        check("r0_oe", {7'd0, oe0}, 8'd1);
        check("r0_ready", {7'd0, rdy0}, 8'd1);
        check("r2_ready_e1", {7'd0, rdy2}, 8'd0);
        addr = 5'd3;
        tick();
        check("r0_hold", dout0, 8'h3C);
        check("r2_ready_e2", {7'd0, rdy2}, 8'd0);
        tick();
        check("r2_ready_e3", {7'd0, rdy2}, 8'd1);
        check("r2_dout", dout2, 8'h3C);
        check("r3_abort_ready", {7'd0, rdy3}, 8'd0);
        rd = 1'b0;
        tick();
        check("r0_oe_fall", {7'd0, oe0}, 8'd0);
        check("r0_ready_fall", {7'd0, rdy0}, 8'd0);
        check("r2_oe_fall", {7'd0, oe2}, 8'd0);
        check("r3_oe", {7'd0, oe3}, 8'd0);
        tick();
        // one-cycle write of 5A to addr 7
        wr = 1'b1; addr = 5'd7; data_in = 8'h5A;
        tick();
        wr = 1'b0; data_in = 8'h00;
        check("w0_ready", {7'd0, rdy0}, 8'd1);
        check("w2_ready_e1", {7'd0, rdy2}, 8'd0);
        tick();
        check("w0_ready_once", {7'd0, rdy0}, 8'd0);
        check("w2_ready_e2", {7'd0, rdy2}, 8'd0);
        tick();
        check("w2_ready_e3", {7'd0, rdy2}, 8'd1);
        check("w3_ready_e3", {7'd0, rdy3}, 8'd0);
        tick();
        check("w2_ready_e4", {7'd0, rdy2}, 8'd0);
        check("w3_ready_e4", {7'd0, rdy3}, 8'd1);
        tick();
        rd = 1'b1;
        tick(3);
        check("w2_readback", dout2, 8'h5A);
        check("w0_readback", dout0, 8'h5A);
        rd = 1'b0;
        tick();
        // collision
        rd = 1'b1; wr = 1'b1; addr = 5'd5; data_in = 8'hFF;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("col_err", {7'd0, err0}, 8'd1);
        check("col_ready", {7'd0, rdy0}, 8'd0);
        check("col_oe", {7'd0, oe0}, 8'd0);
        tick();
        check("col_err_pulse", {7'd0, err0}, 8'd0);
        rd = 1'b1;
        tick();
        check("col_mem", dout0, 8'h3C);
        rd = 1'b0;
        tick();
        // read abort at WAIT_STATES=3
        rd = 1'b1; addr = 5'd5;
        tick();
        rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort_ready_%0d", i), {7'd0, rdy3}, 8'd0);
            check($sformatf("abort_oe_%0d", i), {7'd0, oe3}, 8'd0);
        end
        // error on read during posted write at WAIT_STATES=2
        wr = 1'b1; addr = 5'd9; data_in = 8'h11;
        tick();
        wr = 1'b0; rd = 1'b1;
        tick();
        check("ww_rd_err", {7'd0, err2}, 8'd1);
        rd = 1'b0;
        tick();
        check("ww_err_pulse", {7'd0, err2}, 8'd0);
        check("ww_ready", {7'd0, rdy2}, 8'd1);
        tick(3);
        // reset in WWAIT drops the write
        wr = 1'b1; addr = 5'd5; data_in = 8'h77;
        tick();
        wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rww_ready", {7'd0, rdy2}, 8'd0);
        check("rww_oe", {7'd0, oe2}, 8'd0);
        tick();
        rd = 1'b1;
        tick(3);
        check("rww_kept", dout2, 8'h3C);
        check("rww_w0_commit", dout0, 8'h77);
        rd = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
